program_loader: RTL and testbench



---
 rtl/program_loader.sv | 134 +++++++++++++
 tb/tb_program_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: takes a framed word stream (header + payload) over valid/ready and
// writes each payload word into instruction or data memory through the core's load port.
// The load port is held (loading=1) for the whole session, then done pulses once.
module program_loader #(
    parameter int unsigned ADDRESS_WIDTH = 11,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     loading,
    output logic                     im_cen_load,
    output logic                     im_wen_load,
    output logic                     im_oen_load,
    output logic [ADDRESS_WIDTH-1:0] im_addr_load,
    output logic [DATA_WIDTH-1:0]    im_datain_load,
    output logic                     dm_cen_load,
    output logic                     dm_wen_load,
    output logic                     dm_oen_load,
    output logic [ADDRESS_WIDTH-1:0] dm_addr_load,
    output logic [DATA_WIDTH-1:0]    dm_datain_load,
    output logic                     done,
    output logic                     error
);

    typedef enum logic [2:0] {StIdle, StHeader, StPayload, StDrain, StErr} state_e;

    // Header count/address bits that do not fit in ADDRESS_WIDTH must be zero.
    localparam logic [10:0] HighMask = ~11'((1 << ADDRESS_WIDTH) - 1);

    state_e state_q, state_d;

    logic                     target_q;
    logic                     last_q;
    logic [10:0]              remaining_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     im_we_q, dm_we_q;
    logic [ADDRESS_WIDTH-1:0] im_addr_q, dm_addr_q;
    logic [DATA_WIDTH-1:0]    im_data_q, dm_data_q;
    logic                     done_q;

    logic        accept;
    logic        hdr_target, hdr_last, hdr_ok;
    logic [10:0] hdr_count, hdr_addr;

    assign hdr_target = in_data[31];
    assign hdr_last   = in_data[30];
    assign hdr_count  = in_data[26:16];
    assign hdr_addr   = in_data[10:0];
    assign hdr_ok     = (in_data[29:27] == 3'b000) && (in_data[15:11] == 5'b00000) &&
                        ((hdr_count & HighMask) == 11'd0) && ((hdr_addr & HighMask) == 11'd0);
    assign accept     = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StHeader;
            StHeader:  if (accept) state_d = hdr_ok ? StPayload : StErr;
            StPayload: if (accept && (remaining_q == 11'd0)) state_d = last_q ? StDrain : StHeader;
            StDrain:   state_d = StIdle;
            StErr:     if (start) state_d = StHeader;
            default:   state_d = StIdle;
        endcase
    end

    // Section bookkeeping and registered one-cycle write strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q    <= 1'b0;
            last_q      <= 1'b0;
            remaining_q <= '0;
            addr_q      <= '0;
            im_we_q     <= 1'b0;
            dm_we_q     <= 1'b0;
            im_addr_q   <= '0;
            dm_addr_q   <= '0;
            im_data_q   <= '0;
            dm_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            im_we_q <= 1'b0;
            dm_we_q <= 1'b0;
            done_q  <= (state_q == StDrain);
            if ((state_q == StHeader) && accept && hdr_ok) begin
                target_q    <= hdr_target;
                last_q      <= hdr_last;
                remaining_q <= hdr_count;
                addr_q      <= hdr_addr[ADDRESS_WIDTH-1:0];
            end
            if ((state_q == StPayload) && accept) begin
                remaining_q <= remaining_q - 11'd1;
                addr_q      <= addr_q + 1'b1;  // wraps modulo 2^ADDRESS_WIDTH
                if (target_q) begin
                    dm_we_q   <= 1'b1;
                    dm_addr_q <= addr_q;
                    dm_data_q <= in_data;
                end else begin
                    im_we_q   <= 1'b1;
                    im_addr_q <= addr_q;
                    im_data_q <= in_data;
                end
            end
        end
    end

    // Outputs: decoded from state or taken straight from registers
    always_comb begin
        in_ready       = (state_q == StHeader) || (state_q == StPayload);
        loading        = (state_q == StHeader) || (state_q == StPayload) || (state_q == StDrain);
        error          = (state_q == StErr);
        done           = done_q;
        im_cen_load    = ~im_we_q;
        im_wen_load    = ~im_we_q;
        im_oen_load    = 1'b1;
        im_addr_load   = im_addr_q;
        im_datain_load = im_data_q;
        dm_cen_load    = ~dm_we_q;
        dm_wen_load    = ~dm_we_q;
        dm_oen_load    = 1'b1;
        dm_addr_load   = dm_addr_q;
        dm_datain_load = dm_data_q;
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: expected memory writes are queued as payload words are driven
// and compared against the write strobes seen on the load port.
module tb_program_loader;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          loading;
    logic          im_cen_load, im_wen_load, im_oen_load;
    logic [AW-1:0] im_addr_load;
    logic [DW-1:0] im_datain_load;
    logic          dm_cen_load, dm_wen_load, dm_oen_load;
    logic [AW-1:0] dm_addr_load;
    logic [DW-1:0] dm_datain_load;
    logic          done, error;

    program_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .loading(loading),
        .im_cen_load(im_cen_load), .im_wen_load(im_wen_load), .im_oen_load(im_oen_load),
        .im_addr_load(im_addr_load), .im_datain_load(im_datain_load),
        .dm_cen_load(dm_cen_load), .dm_wen_load(dm_wen_load), .dm_oen_load(dm_oen_load),
        .dm_addr_load(dm_addr_load), .dm_datain_load(dm_datain_load),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          dm;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           sb_q[$];
    wr_t           mon_e;
    int            strobe_cyc[$];
    int            checks = 0;
    int            errors = 0;
    int            cycle = 0;
    int            done_cnt = 0;
    int            load_drops = 0;
    bit            in_session = 1'b0;
    logic          cur_dm = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic          im_st, dm_st;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued write
    always @(negedge clk) begin
        im_st = !im_cen_load && !im_wen_load;
        dm_st = !dm_cen_load && !dm_wen_load;
        if (im_st || dm_st) begin
            strobe_cyc.push_back(cycle);
            check_eq("one_target", 32'(im_st && dm_st), 0);
            check_eq("oen_high", {30'b0, im_oen_load, dm_oen_load}, 3);
            check_eq("sb_nonempty", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check_eq("wr_target", 32'(dm_st), 32'(mon_e.dm));
                check_eq("wr_addr", dm_st ? dm_addr_load : im_addr_load, mon_e.addr);
                check_eq("wr_data", dm_st ? dm_datain_load : im_datain_load, mon_e.data);
            end
        end
        if (done === 1'b1) done_cnt++;
        if (in_session && loading !== 1'b1 && done !== 1'b1) load_drops++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    // All tasks enter and leave 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int gap);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("handshake", 32'(ok), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_header(input logic [DW-1:0] h);
        cur_dm   = h[31];
        cur_addr = h[AW-1:0];
        send_word(h, 0);
    endtask

    task automatic send_payload(input logic [DW-1:0] w, input int gap);
        sb_q.push_back(wr_t'{dm: cur_dm, addr: cur_addr, data: w});
        cur_addr = cur_addr + 1'b1;
        send_word(w, gap);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        in_session = 1'b0;
        check_eq("done_seen", 32'(ok), 1);
        if (ok) begin
            check_eq("loading_falls_with_done", 32'(loading), 0);
            @(negedge clk);
            check_eq("done_one_cycle", 32'(done), 0);
        end
        @(posedge clk);
        #1;
    endtask

    int s0, d0, l0;

    initial begin
        do_reset();
        check_eq("rst_ctrl", {27'b0, loading, in_ready, done, error, 1'b0}, 0);
        check_eq("rst_strobes", {26'b0, im_cen_load, im_wen_load, im_oen_load,
                                 dm_cen_load, dm_wen_load, dm_oen_load}, 32'h3f);
        check_eq("rst_addr", {im_addr_load, dm_addr_load}, 0);
        check_eq("rst_data", im_datain_load | dm_datain_load, 0);

        // 1: single IM section, back-to-back payload
        s0 = strobe_cyc.size(); d0 = done_cnt;
        pulse_start();
        check_eq("t1_loading_after_start", {30'b0, loading, in_ready}, 3);
        in_session = 1'b1;
        send_header(32'h4002_0010);
        send_payload(32'hA, 0);
        send_payload(32'hB, 0);
        send_payload(32'hC, 0);
        wait_done();
        check_eq("t1_strobes", strobe_cyc.size() - s0, 3);
        if (strobe_cyc.size() - s0 == 3)
            check_eq("t1_consecutive", strobe_cyc[s0+2] - strobe_cyc[s0], 2);
        check_eq("t1_done_count", done_cnt - d0, 1);

        // 2: IM section then DM section with address wrap
        l0 = load_drops; d0 = done_cnt;
        pulse_start();
        in_session = 1'b1;
        send_header(32'h0000_0000);
        send_payload(32'h11, 0);
        send_header(32'hC001_07FF);
        send_payload(32'h22, 0);
        send_payload(32'h33, 0);
        wait_done();
        check_eq("t2_loading_held", load_drops - l0, 0);
        check_eq("t2_done_count", done_cnt - d0, 1);

        // 3: gaps between payload words
        s0 = strobe_cyc.size();
        pulse_start();
        in_session = 1'b1;
        send_header(32'h4002_0010);
        send_payload(32'hA, 2);
        send_payload(32'hB, 2);
        send_payload(32'hC, 0);
        wait_done();
        check_eq("t3_strobes", strobe_cyc.size() - s0, 3);
        if (strobe_cyc.size() - s0 == 3) begin
            check_eq("t3_gap0", strobe_cyc[s0+1] - strobe_cyc[s0], 3);
            check_eq("t3_gap1", strobe_cyc[s0+2] - strobe_cyc[s0+1], 3);
        end

        // 4: bad header, sticky error, recovery by start
        s0 = strobe_cyc.size();
        pulse_start();
        send_header(32'h2000_0000);
        @(negedge clk);
        check_eq("t4_err_state", {29'b0, error, loading, in_ready}, 32'h4);
        repeat (3) @(negedge clk);
        check_eq("t4_err_sticky", 32'(error), 1);
        @(posedge clk);
        #1;
        pulse_start();
        check_eq("t4_recover", {29'b0, error, loading, in_ready}, 32'h3);
        check_eq("t4_no_strobes", strobe_cyc.size() - s0, 0);
        do_reset();

        // 5: reset after the first payload word
        s0 = strobe_cyc.size(); d0 = done_cnt;
        pulse_start();
        send_header(32'h4002_0010);
        send_payload(32'hA, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("t5_after_rst", {28'b0, loading, done, im_cen_load, dm_cen_load}, 32'h3);
        repeat (4) @(negedge clk);
        check_eq("t5_one_write", strobe_cyc.size() - s0, 1);
        check_eq("t5_sb_drained", sb_q.size(), 0);
        check_eq("t5_no_done", done_cnt - d0, 0);
        @(posedge clk);
        #1;

        // 6: start during PAYLOAD is ignored
        d0 = done_cnt;
        pulse_start();
        in_session = 1'b1;
        send_header(32'h4002_0010);
        send_payload(32'hA, 0);
        pulse_start();
        check_eq("t6_still_payload", {30'b0, loading, in_ready}, 3);
        send_payload(32'hB, 0);
        send_payload(32'hC, 0);
        wait_done();
        check_eq("t6_done_count", done_cnt - d0, 1);

        repeat (3) @(posedge clk);
        check_eq("sb_empty_at_end", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
